// File: rtl/text_ram_arbiter.sv
// Text RAM port arbiter: shares one RAM port between display reads and a queue
// of character write/erase entries, and owns the whole-buffer clear sweep.
module text_ram_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CLR_TOP    = 511
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vga_read_req,
  input  logic [8:0] vga_addr,
  input  logic       wr_req,
  input  logic [8:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       erase_req,
  input  logic [8:0] erase_addr,
  input  logic       clear_req,
  output logic       wr_ack,
  output logic       erase_ack,
  output logic [8:0] ram_addr,
  output logic [7:0] ram_din,
  output logic       ram_we,
  output logic       ram_erase,
  output logic       vga_grant,
  output logic       busy_clear,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       addr_err
);

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  typedef struct packed {
    logic              erase;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;

  entry_t            r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_idle;
  logic              w_ack_any;
  logic              w_addr_ok;
  logic              w_push;
  logic              w_pop;
  entry_t            w_entry;
  entry_t            w_head;

  logic              w_we_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_din_nxt;
  logic              w_erase_nxt;
  logic              w_grant_nxt;

  assign w_idle     = (r_state == ST_IDLE);
  assign busy_clear = (r_state == ST_CLEAR);
  assign fifo_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (r_count == '0);

  // Write beats erase; nothing is accepted while clearing or when a clear is requested.
  assign wr_ack    = wr_req && !fifo_full && w_idle && !clear_req;
  assign erase_ack = erase_req && !wr_req && !fifo_full && w_idle && !clear_req;
  assign w_ack_any = wr_ack || erase_ack;

  always_comb begin
    w_entry.erase = !wr_ack;
    w_entry.addr  = wr_ack ? wr_addr : erase_addr;
    w_entry.data  = wr_ack ? wr_data : 8'h00;
  end

  // Visible screen is 15 rows x 20 columns.
  assign w_addr_ok = (w_entry.addr[8:5] <= 4'd14) && (w_entry.addr[4:0] <= 5'd19);
  assign w_push    = w_ack_any && w_addr_ok;

  // A pending clear discards the queue, so do not spend its cycle on a pop.
  assign w_pop  = w_idle && !clear_req && !fifo_empty && (!vga_read_req || fifo_full);
  assign w_head = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clear_req) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Next state, sweep counter and RAM port drive.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = '0;
    w_din_nxt   = '0;
    w_erase_nxt = 1'b0;
    w_grant_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pop) begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = w_head.addr;
          w_din_nxt   = w_head.data;
          w_erase_nxt = w_head.erase;
        end else begin
          w_addr_nxt  = vga_addr;
          w_grant_nxt = vga_read_req;
        end
        if (clear_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = ADDR_W'(CLR_TOP);
        end
      end
      ST_CLEAR: begin
        w_we_nxt   = 1'b1;
        w_addr_nxt = r_cnt;
        if (clear_req) begin
          w_cnt_nxt = ADDR_W'(CLR_TOP);
        end else begin
          w_cnt_nxt = r_cnt - ADDR_W'(1);
          if (r_cnt == '0) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt   = ADDR_W'(CLR_TOP);
      end
    endcase
  end

  // Reset lands in CLEAR so every reset is followed by a full zeroing sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= ADDR_W'(CLR_TOP);
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_erase <= 1'b0;
      vga_grant <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      ram_we    <= w_we_nxt;
      ram_addr  <= w_addr_nxt;
      ram_din   <= w_din_nxt;
      ram_erase <= w_erase_nxt;
      vga_grant <= w_grant_nxt;
      addr_err  <= w_ack_any && !w_addr_ok;
    end
  end

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Bench for text_ram_arbiter: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_text_ram_arbiter;

  localparam int DEPTH   = 4;
  localparam int CLR_TOP = 511;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vga_read_req = 1'b0;
  logic [8:0] vga_addr = '0;
  logic       wr_req = 1'b0;
  logic [8:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       erase_req = 1'b0;
  logic [8:0] erase_addr = '0;
  logic       clear_req = 1'b0;
  logic       wr_ack, erase_ack;
  logic [8:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_we, ram_erase, vga_grant, busy_clear, fifo_full, fifo_empty, addr_err;

  text_ram_arbiter #(.FIFO_DEPTH(DEPTH), .CLR_TOP(CLR_TOP)) dut (
    .clk(clk), .rst(rst),
    .vga_read_req(vga_read_req), .vga_addr(vga_addr),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .erase_req(erase_req), .erase_addr(erase_addr),
    .clear_req(clear_req),
    .wr_ack(wr_ack), .erase_ack(erase_ack),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_erase(ram_erase),
    .vga_grant(vga_grant), .busy_clear(busy_clear),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending entries, sweep position, expected registered outputs.
  typedef struct {
    bit er;
    int addr;
    int data;
  } ent_t;

  ent_t q[$];
  ent_t m_ent;
  bit   m_clearing = 1'b1;
  int   m_sweep = CLR_TOP;
  int   e_we = 0, e_addr = 0, e_din = 0, e_erase = 0, e_grant = 0, e_err = 0;
  bit   m_full, m_ackw, m_acke;
  int   m_a;

  task automatic model_step();
    if (rst) begin
      m_clearing = 1'b1;
      m_sweep = CLR_TOP;
      q.delete();
      e_we = 0; e_addr = 0; e_din = 0; e_erase = 0; e_grant = 0; e_err = 0;
    end else if (m_clearing) begin
      e_we = 1; e_addr = m_sweep; e_din = 0; e_erase = 0; e_grant = 0; e_err = 0;
      if (clear_req) m_sweep = CLR_TOP;
      else if (m_sweep == 0) m_clearing = 1'b0;
      else m_sweep = m_sweep - 1;
    end else begin
      m_full = (q.size() == DEPTH);
      m_ackw = wr_req && !m_full && !clear_req;
      m_acke = erase_req && !wr_req && !m_full && !clear_req;
      if (q.size() != 0 && !clear_req && (!vga_read_req || m_full)) begin
        m_ent = q.pop_front();
        e_we = 1; e_addr = m_ent.addr; e_din = m_ent.data; e_erase = int'(m_ent.er); e_grant = 0;
      end else begin
        e_we = 0; e_addr = int'(vga_addr); e_din = 0; e_erase = 0; e_grant = int'(vga_read_req);
      end
      e_err = 0;
      if (m_ackw || m_acke) begin
        m_a = m_ackw ? int'(wr_addr) : int'(erase_addr);
        if ((m_a / 32) <= 14 && (m_a % 32) <= 19) begin
          m_ent.er = m_acke;
          m_ent.addr = m_a;
          m_ent.data = m_ackw ? int'(wr_data) : 0;
          q.push_back(m_ent);
        end else begin
          e_err = 1;
        end
      end
      if (clear_req) begin
        q.delete();
        m_clearing = 1'b1;
        m_sweep = CLR_TOP;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Every-cycle comparison, sampled mid-cycle on the falling edge.
  initial forever begin
    @(negedge clk);
    chk("ram_we", int'(ram_we), e_we);
    chk("ram_addr", int'(ram_addr), e_addr);
    chk("ram_din", int'(ram_din), e_din);
    chk("ram_erase", int'(ram_erase), e_erase);
    chk("vga_grant", int'(vga_grant), e_grant);
    chk("addr_err", int'(addr_err), e_err);
    chk("busy_clear", int'(busy_clear), int'(m_clearing));
    chk("fifo_full", int'(fifo_full), int'(q.size() == DEPTH));
    chk("fifo_empty", int'(fifo_empty), int'(q.size() == 0));
    chk("wr_ack", int'(wr_ack),
        int'(wr_req && q.size() < DEPTH && !m_clearing && !clear_req));
    chk("erase_ack", int'(erase_ack),
        int'(erase_req && !wr_req && q.size() < DEPTH && !m_clearing && !clear_req));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs until the sweep ends; returns busy cycles and zero-writes seen.
  task automatic wait_sweep(output int n, output int nwe);
    n = 0;
    nwe = 0;
    while (busy_clear && n < 2000) begin
      n++;
      step();
      if (ram_we && ram_din == 8'h00 && !ram_erase) nwe++;
    end
  endtask

  int n, nwe, a;
  int got_addr[2], got_din[2], got_er[2];

  initial begin
    step();
    step();
    chk("rst_ram_we", int'(ram_we), 0);
    chk("rst_busy_clear", int'(busy_clear), 1);
    chk("rst_fifo_empty", int'(fifo_empty), 1);
    rst = 1'b0;
    vga_read_req = 1'b1;
    vga_addr = 9'h0AA;

    // Power-up sweep: 512 busy cycles, 512 zero writes 511 down to 0.
    wait_sweep(n, nwe);
    chk("sweep_cycles", n, 512);
    chk("sweep_writes", nwe, 512);
    chk("sweep_last_addr", int'(ram_addr), 0);
    step();
    chk("idle_grant", int'(vga_grant), 1);
    chk("idle_read_addr", int'(ram_addr), 'h0AA);

    // Single write, display idle.
    vga_read_req = 1'b0;
    wr_req = 1'b1; wr_addr = 9'h023; wr_data = 8'h41;
    #2 chk("w1_ack", int'(wr_ack), 1);
    step();
    wr_req = 1'b0;
    chk("w1_read_slot", int'(ram_we), 0);
    step();
    chk("w1_we", int'(ram_we), 1);
    chk("w1_addr", int'(ram_addr), 'h023);
    chk("w1_din", int'(ram_din), 'h41);
    chk("w1_erase", int'(ram_erase), 0);

    // Display saturating the port: four writes fill the queue, fifth waits for a stolen slot.
    vga_read_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_req = 1'b1; wr_addr = 9'(i + 1); wr_data = 8'(8'h10 + i);
      #2 chk("fill_ack", int'(wr_ack), 1);
      step();
    end
    wr_addr = 9'h005; wr_data = 8'h14;
    #2 chk("full_flag", int'(fifo_full), 1);
    chk("full_noack", int'(wr_ack), 0);
    step();
    #2 chk("steal_ack", int'(wr_ack), 1);
    chk("steal_grant", int'(vga_grant), 0);
    chk("steal_we", int'(ram_we), 1);
    chk("steal_addr", int'(ram_addr), 'h001);
    step();
    wr_req = 1'b0;
    vga_read_req = 1'b0;
    repeat (8) step();
    chk("drained", int'(fifo_empty), 1);

    // Off-screen addresses are acked but dropped.
    vga_read_req = 1'b1;
    wr_req = 1'b1; wr_addr = 9'h014; wr_data = 8'h7E;
    #2 chk("col20_ack", int'(wr_ack), 1);
    step();
    wr_addr = 9'h1E0;
    chk("col20_err", int'(addr_err), 1);
    chk("col20_empty", int'(fifo_empty), 1);
    #2 chk("row15_ack", int'(wr_ack), 1);
    step();
    wr_req = 1'b0;
    chk("row15_err", int'(addr_err), 1);
    chk("row15_empty", int'(fifo_empty), 1);
    step();
    chk("err_pulse_end", int'(addr_err), 0);

    // Write and erase to the same cell in the same cycle.
    wr_req = 1'b1; wr_addr = 9'h040; wr_data = 8'h55;
    erase_req = 1'b1; erase_addr = 9'h040;
    #2 chk("coll_wr_ack", int'(wr_ack), 1);
    chk("coll_er_ack0", int'(erase_ack), 0);
    step();
    wr_req = 1'b0;
    #2 chk("coll_er_ack1", int'(erase_ack), 1);
    step();
    erase_req = 1'b0;
    vga_read_req = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      step();
      if (ram_we) begin
        got_addr[n] = int'(ram_addr);
        got_din[n] = int'(ram_din);
        got_er[n] = int'(ram_erase);
        n++;
      end
    end
    chk("coll_writes", n, 2);
    if (n == 2) begin
      chk("coll_1st_addr", got_addr[0], 'h040);
      chk("coll_1st_din", got_din[0], 'h55);
      chk("coll_1st_er", got_er[0], 0);
      chk("coll_2nd_addr", got_addr[1], 'h040);
      chk("coll_2nd_din", got_din[1], 0);
      chk("coll_2nd_er", got_er[1], 1);
    end

    // Clear flushes queued entries, and a second clear restarts the sweep.
    vga_read_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_req = 1'b1; wr_addr = 9'(9'h061 + i); wr_data = 8'(8'hC0 + i);
      step();
    end
    wr_req = 1'b0;
    chk("preclear_count3", int'(fifo_empty), 0);
    clear_req = 1'b1;
    wr_req = 1'b1; wr_addr = 9'h070; wr_data = 8'h99;
    #2 chk("clear_noack", int'(wr_ack), 0);
    step();
    clear_req = 1'b0;
    wr_req = 1'b0;
    chk("clear_flush", int'(fifo_empty), 1);
    chk("clear_busy", int'(busy_clear), 1);
    repeat (100) step();
    a = int'(ram_addr);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    chk("restart_prev", int'(ram_addr), a - 1);
    step();
    chk("restart_top", int'(ram_addr), 511);
    wait_sweep(n, nwe);
    chk("restart_cycles", n, 511);
    chk("restart_last", int'(ram_addr), 0);

    // Reset mid-drain discards queued work and starts a fresh sweep.
    step();
    for (int i = 0; i < 2; i++) begin
      wr_req = 1'b1; wr_addr = 9'(9'h0A1 + i); wr_data = 8'(8'hE0 + i);
      step();
    end
    wr_req = 1'b0;
    rst = 1'b1;
    #1 chk("rst_mid_empty", int'(fifo_empty), 1);
    chk("rst_mid_we", int'(ram_we), 0);
    step();
    step();
    rst = 1'b0;
    chk("rst_rel_busy", int'(busy_clear), 1);
    wait_sweep(n, nwe);
    chk("rst_sweep_cycles", n, 512);
    chk("rst_sweep_writes", nwe, 512);
    step();
    chk("rst_final_empty", int'(fifo_empty), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
